game_state_ctrl: RTL
====================

Name: game_state_ctrl

Overview:
- Level-progression FSM and sun economy for Plants vs Zombies.
- Sits directly upstream of the VGA top-level integration and the seven-segment counter.
- Produces the one-hot 8-bit game state, the sun balance (numSuns) and the total kill count (zombies_killed).
- Consumes the debounced select pulse, kill/breach events from the zombie logic, and plant-purchase requests from the cursor/placement logic.

Parameters:
- SUN_PERIOD, 500000000: clock cycles between automatic sun grants (5 s at 100 MHz).
- SUN_INC, 25: suns added per grant.
- SUN_MAX, 9999: saturation ceiling for the sun balance (4-digit SSD).
- SUN_INIT, 50: balance loaded on entry to L1.
- KILLS_L1, 5: kills required to clear level 1.
- KILLS_L2, 10: kills required to clear level 2.
- KILLS_L3, 15: kills required to clear level 3.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- select_pulse  in  1  single-cycle debounced BtnC pulse.
- zombie_killed  in  1  single-cycle pulse, one zombie destroyed.
- zombie_breach  in  1  single-cycle pulse, a zombie reached the house.
- plant_req  in  1  single-cycle purchase request.
- plant_cost  in  16  cost of the requested plant; sampled with plant_req.
- plant_ack  out  1  single-cycle pulse, purchase granted.
- plant_nack  out  1  single-cycle pulse, purchase refused.
- state  out  8  one-hot: I=1000_0000, L1=0100_0000, NL2=0010_0000, L2=0001_0000, NL3=0000_1000, L3=0000_0100, DoneL=0000_0010, DoneW=0000_0001.
- num_suns  out  16  current sun balance, binary.
- zombies_killed  out  16  total kills since leaving I, binary.
- level_kills  out  8  kills in the current level.

Behaviour:
- Reset (sync, overrides all other inputs): state=I; num_suns=0; zombies_killed=0; level_kills=0; sun timer=0; plant_ack=plant_nack=0.
- All outputs are registered. Every event takes effect in the cycle after it is sampled.
- FSM transitions:
  - I + select_pulse -> L1. On entry: num_suns=SUN_INIT, zombies_killed=0, level_kills=0, timer=0.
  - L1/L2/L3 + zombie_breach -> DoneL.
  - L1 when level_kills reaches KILLS_L1 -> NL2.
  - L2 when level_kills reaches KILLS_L2 -> NL3.
  - L3 when level_kills reaches KILLS_L3 -> DoneW.
  - The "reaches" check uses the post-increment value, so the transition happens in the cycle after the last kill pulse.
  - NL2 + select_pulse -> L2; NL3 + select_pulse -> L3. On entry: level_kills=0, timer=0; num_suns and zombies_killed carry over.
  - DoneL/DoneW + select_pulse -> I. num_suns and zombies_killed hold their values until the next L1 entry.
- Simultaneous breach and final kill in the same cycle: breach wins -> DoneL. The kill is still counted.
- Inputs outside L states: zombie_killed, zombie_breach and plant_req are ignored. For plant_req this means no ack and no nack.
- Sun timer:
  - Runs only in L states and is frozen elsewhere.
  - When the count reaches SUN_PERIOD-1, it wraps to 0 and num_suns += SUN_INC, saturating at SUN_MAX.
- Purchase (L states only):
  - plant_req with pre-cycle num_suns >= plant_cost: next cycle num_suns -= plant_cost and plant_ack=1.
  - Otherwise plant_nack=1 and the balance is unchanged.
  - plant_cost=0 is always acked.
- Grant and purchase in the same cycle: the affordability check uses the pre-cycle balance. Result = min(balance - cost + SUN_INC, SUN_MAX).
- A purchase is still resolved in the same cycle as a level-exit transition.
- Counter saturation: zombies_killed saturates at 65535; level_kills saturates at 255.
- select_pulse in L states is ignored.
- Reset mid-level takes effect on the next clock edge regardless of pending req/pulses. No ack/nack is emitted for a request sampled together with reset.

Test Plan:
- Reset, then select_pulse: state 0x80 -> 0x40, num_suns=50, zombies_killed=0.
- SUN_PERIOD=10 in L1: after 10 cycles num_suns=75; after 4 more grants from 9990, num_suns=9999 (saturation).
- Balance 50: plant_req cost 50 -> ack, num_suns=0; then plant_req cost 25 -> nack, num_suns=0; plant_req while in NL2 -> no ack/nack.
- Grant and req in the same cycle with balance 40, cost 50: nack, num_suns=65. Balance 50, cost 50: ack, num_suns=25.
- Progression:
  - 5 kills in L1 -> NL2, level_kills=0, zombies_killed=5.
  - select_pulse -> L2; 10 kills -> NL3.
  - select_pulse -> L3; 15 kills -> DoneW (0x01), zombies_killed=30.
  - select_pulse -> I.
- In L2 with level_kills=9: zombie_killed and zombie_breach in the same cycle -> DoneL (0x02), zombies_killed incremented. Reset asserted mid-L3 -> state=0x80, all counters 0 on the next edge.

Source files
------------

// File: rtl/game_state_ctrl_if.sv
// Control/status bundle between game_state_ctrl and its neighbours (input
// debouncer, zombie logic, placement logic, VGA and seven-segment display).
interface game_state_ctrl_if;
    logic        select_pulse;
    logic        zombie_killed;
    logic        zombie_breach;
    logic        plant_req;
    logic [15:0] plant_cost;
    logic        plant_ack;
    logic        plant_nack;
    logic [7:0]  state;
    logic [15:0] num_suns;
    logic [15:0] zombies_killed;
    logic [7:0]  level_kills;

    modport slave (
        input  select_pulse, zombie_killed, zombie_breach, plant_req, plant_cost,
        output plant_ack, plant_nack, state, num_suns, zombies_killed, level_kills
    );

    modport master (
        output select_pulse, zombie_killed, zombie_breach, plant_req, plant_cost,
        input  plant_ack, plant_nack, state, num_suns, zombies_killed, level_kills
    );
endinterface

// File: rtl/game_state_ctrl.sv
// Level progression FSM and sun economy: one-hot game state, sun balance with
// periodic grants and purchases, and kill counters. All outputs registered.
module game_state_ctrl #(
    parameter int unsigned SUN_PERIOD = 500000000,
    parameter int unsigned SUN_INC    = 25,
    parameter int unsigned SUN_MAX    = 9999,
    parameter int unsigned SUN_INIT   = 50,
    parameter int unsigned KILLS_L1   = 5,
    parameter int unsigned KILLS_L2   = 10,
    parameter int unsigned KILLS_L3   = 15
) (
    input logic              clk,
    input logic              reset,
    game_state_ctrl_if.slave gif
);

    localparam int unsigned TW = (SUN_PERIOD > 1) ? $clog2(SUN_PERIOD) : 1;

    typedef enum logic [7:0] {
        ST_I     = 8'b1000_0000,
        ST_L1    = 8'b0100_0000,
        ST_NL2   = 8'b0010_0000,
        ST_L2    = 8'b0001_0000,
        ST_NL3   = 8'b0000_1000,
        ST_L3    = 8'b0000_0100,
        ST_DONEL = 8'b0000_0010,
        ST_DONEW = 8'b0000_0001
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   num_suns_q, num_suns_d;
    logic [15:0]   zombies_killed_q, zombies_killed_d;
    logic [7:0]    level_kills_q, level_kills_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          plant_ack_q, plant_ack_d;
    logic          plant_nack_q, plant_nack_d;

    logic          grant;
    logic [16:0]   bal;
    logic [16:0]   sum;
    logic [7:0]    target;
    state_e        nxt_lvl;

    assign grant = (timer_q == TW'(SUN_PERIOD - 1));

    always_comb begin
        state_d          = state_q;
        num_suns_d       = num_suns_q;
        zombies_killed_d = zombies_killed_q;
        level_kills_d    = level_kills_q;
        timer_d          = timer_q;
        plant_ack_d      = 1'b0;
        plant_nack_d     = 1'b0;
        bal              = {1'b0, num_suns_q};
        sum              = '0;
        target           = 8'(KILLS_L3);
        nxt_lvl          = ST_DONEW;

        unique case (state_q)
            ST_I: begin
                if (gif.select_pulse) begin
                    state_d          = ST_L1;
                    num_suns_d       = 16'(SUN_INIT);
                    zombies_killed_d = '0;
                    level_kills_d    = '0;
                    timer_d          = '0;
                end
            end
            ST_NL2, ST_NL3: begin
                if (gif.select_pulse) begin
                    state_d       = (state_q == ST_NL2) ? ST_L2 : ST_L3;
                    level_kills_d = '0;
                    timer_d       = '0;
                end
            end
            ST_DONEL, ST_DONEW: begin
                if (gif.select_pulse) state_d = ST_I;
            end
            ST_L1, ST_L2, ST_L3: begin
                timer_d = grant ? '0 : timer_q + 1'b1;

                // Affordability is judged on the balance before any grant this cycle.
                if (gif.plant_req) begin
                    if (num_suns_q >= gif.plant_cost) begin
                        bal         = {1'b0, num_suns_q} - {1'b0, gif.plant_cost};
                        plant_ack_d = 1'b1;
                    end else begin
                        plant_nack_d = 1'b1;
                    end
                end
                if (grant) begin
                    sum        = bal + 17'(SUN_INC);
                    num_suns_d = (sum > 17'(SUN_MAX)) ? 16'(SUN_MAX) : sum[15:0];
                end else begin
                    num_suns_d = bal[15:0];
                end

                if (gif.zombie_killed) begin
                    if (zombies_killed_q != 16'hFFFF) zombies_killed_d = zombies_killed_q + 1'b1;
                    if (level_kills_q != 8'hFF)       level_kills_d    = level_kills_q + 1'b1;
                end

                if (state_q == ST_L1) begin
                    target  = 8'(KILLS_L1);
                    nxt_lvl = ST_NL2;
                end else if (state_q == ST_L2) begin
                    target  = 8'(KILLS_L2);
                    nxt_lvl = ST_NL3;
                end

                // A breach beats a simultaneous level-clearing kill; the kill still counts.
                if (gif.zombie_breach) begin
                    state_d = ST_DONEL;
                end else if (level_kills_d >= target) begin
                    state_d = nxt_lvl;
                    if (nxt_lvl != ST_DONEW) level_kills_d = '0;
                end
            end
            default: state_d = ST_I;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_I;
            num_suns_q       <= '0;
            zombies_killed_q <= '0;
            level_kills_q    <= '0;
            timer_q          <= '0;
            plant_ack_q      <= 1'b0;
            plant_nack_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            num_suns_q       <= num_suns_d;
            zombies_killed_q <= zombies_killed_d;
            level_kills_q    <= level_kills_d;
            timer_q          <= timer_d;
            plant_ack_q      <= plant_ack_d;
            plant_nack_q     <= plant_nack_d;
        end
    end

    assign gif.state          = state_q;
    assign gif.num_suns       = num_suns_q;
    assign gif.zombies_killed = zombies_killed_q;
    assign gif.level_kills    = level_kills_q;
    assign gif.plant_ack      = plant_ack_q;
    assign gif.plant_nack     = plant_nack_q;

endmodule
